// File: rtl/envelope_vca_pwm_if.sv
// Sample/product handshake bundle between the oscillator/ADSR pair and the VCA.
// sample_valid/sample_ready: a sample transfers on any clock edge where both are high.
interface envelope_vca_pwm_if;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       sample_ready;
    logic [7:0] amplitude;
    logic [7:0] product_out;
    logic       product_valid;

    modport master (
        output sample_in,
        output sample_valid,
        output amplitude,
        input  sample_ready,
        input  product_out,
        input  product_valid
    );

    modport slave (
        input  sample_in,
        input  sample_valid,
        input  amplitude,
        output sample_ready,
        output product_out,
        output product_valid
    );
endinterface

// File: rtl/envelope_vca_pwm.sv
// VCA: sequential shift-add sample*amplitude, result drives a double-buffered PWM DAC.
// Optional macro VCA_ROUND_EN selects round-half-up instead of truncation of the 16-bit product.
module envelope_vca_pwm #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    envelope_vca_pwm_if.slave   bus,
    output logic                pwm_out,
    output logic                busy,
    output logic [1:0]          dbg_state,
    output logic [15:0]         dbg_acc
);

    if (PWM_BITS != 8) begin : g_bad_cfg
        $error("envelope_vca_pwm: PWM_BITS must be 8");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           mcand_q, mcand_d;
    logic [7:0]            mplier_q, mplier_d;
    logic [15:0]           acc_q, acc_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            product_q, product_d;
    logic                  product_valid_q, product_valid_d;
    logic [7:0]            shadow_q, shadow_d;
    logic [7:0]            active_q, active_d;
    logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic                  pwm_q, pwm_d;
    logic [7:0]            result;

`ifdef VCA_ROUND_EN
    // Max product 65025 + 128 still fits in 16 bits, so no carry is lost.
    logic [15:0] rounded;
    assign rounded = acc_q + 16'd128;
    assign result  = rounded[15:8];
`else
    assign result  = acc_q[15:8];
`endif

    always_comb begin
        state_d         = state_q;
        mcand_d         = mcand_q;
        mplier_d        = mplier_q;
        acc_d           = acc_q;
        bit_cnt_d       = bit_cnt_q;
        product_d       = product_q;
        product_valid_d = 1'b0;
        shadow_d        = shadow_q;

        case (state_q)
            IDLE: begin
                if (bus.sample_valid) begin
                    mcand_d   = {8'd0, bus.sample_in};
                    mplier_d  = bus.amplitude;
                    acc_d     = 16'd0;
                    bit_cnt_d = 3'd0;
                    state_d   = MUL;
                end
            end
            MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d   = mcand_q << 1;
                mplier_d  = mplier_q >> 1;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                product_d       = result;
                product_valid_d = 1'b1;
                shadow_d        = result;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Active duty only changes at the period boundary; a same-cycle shadow write waits a period.
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        active_d  = (pwm_cnt_q == '1) ? shadow_q : active_q;
        pwm_d     = (pwm_cnt_q < active_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            mcand_q         <= 16'd0;
            mplier_q        <= 8'd0;
            acc_q           <= 16'd0;
            bit_cnt_q       <= 3'd0;
            product_q       <= 8'd0;
            product_valid_q <= 1'b0;
            shadow_q        <= 8'd0;
            active_q        <= 8'd0;
            pwm_cnt_q       <= '0;
            pwm_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            mcand_q         <= mcand_d;
            mplier_q        <= mplier_d;
            acc_q           <= acc_d;
            bit_cnt_q       <= bit_cnt_d;
            product_q       <= product_d;
            product_valid_q <= product_valid_d;
            shadow_q        <= shadow_d;
            active_q        <= active_d;
            pwm_cnt_q       <= pwm_cnt_d;
            pwm_q           <= pwm_d;
        end
    end

    assign bus.sample_ready  = (state_q == IDLE);
    assign bus.product_out   = product_q;
    assign bus.product_valid = product_valid_q;
    assign pwm_out           = pwm_q;
    assign busy              = (state_q != IDLE);
    assign dbg_state         = state_q;
    assign dbg_acc           = acc_q;

endmodule

// File: tb/tb_envelope_vca_pwm.sv
// Bench for envelope_vca_pwm: scoreboarded products plus a cycle-level reference of ready and PWM.
module tb_envelope_vca_pwm;

    logic        clk = 1'b0;
    logic        rst;
    logic        pwm_out;
    logic        busy;
    logic [1:0]  dbg_state;
    logic [15:0] dbg_acc;

    envelope_vca_pwm_if vif();

    envelope_vca_pwm #(.PWM_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (vif),
        .pwm_out   (pwm_out),
        .busy      (busy),
        .dbg_state (dbg_state),
        .dbg_acc   (dbg_acc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [7:0] exp_q[$];
    int         due_q[$];

    // Reference state: m_* is what the DUT holds now, n_* is what it will hold after the next edge.
    logic [7:0] m_cnt = 8'd0, m_active = 8'd0, m_shadow = 8'd0;
    logic [7:0] n_cnt = 8'd0, n_active = 8'd0;
    logic       m_pwm = 1'b0, n_pwm = 1'b0;
    int         m_wait = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    endtask

    function automatic logic [7:0] exp_prod(input logic [7:0] s, input logic [7:0] a);
        logic [16:0] p;
        p = 17'(s) * 17'(a);
`ifdef VCA_ROUND_EN
        p = p + 17'd128;
`endif
        return p[15:8];
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            m_cnt = 8'd0; m_active = 8'd0; m_shadow = 8'd0; m_pwm = 1'b0;
            n_cnt = 8'd0; n_active = 8'd0; n_pwm = 1'b0;
            m_wait = 0;
            exp_q.delete();
            due_q.delete();
        end else begin
            m_cnt = n_cnt; m_active = n_active; m_pwm = n_pwm;
            check_eq("pwm", pwm_out, m_pwm);
            check_eq("ready", vif.sample_ready, m_wait == 0);
            check_eq("busy", busy, m_wait != 0);

            if (vif.product_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexp_valid", vif.product_valid, 0);
                end else begin
                    logic [7:0] e;
                    int d;
                    e = exp_q.pop_front();
                    d = due_q.pop_front();
                    check_eq("product", vif.product_out, e);
                    check_eq("latency", cyc, d);
                    m_shadow = e;
                end
            end else if (due_q.size() != 0 && cyc > due_q[0]) begin
                check_eq("missing_valid", vif.product_valid, 1);
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end

            if (vif.sample_valid && m_wait == 0) begin
                exp_q.push_back(exp_prod(vif.sample_in, vif.amplitude));
                due_q.push_back(cyc + 10);
                m_wait = 9;
            end else if (m_wait > 0) begin
                m_wait--;
            end

            n_pwm    = (m_cnt < m_active);
            n_active = (m_cnt == 8'hff) ? m_shadow : m_active;
            n_cnt    = m_cnt + 8'd1;
        end
    end

    task automatic drive_sample(input logic [7:0] s, input logic [7:0] a);
        @(posedge clk); #1;
        vif.sample_valid = 1'b1;
        vif.sample_in    = s;
        vif.amplitude    = a;
        @(posedge clk); #1;
        vif.sample_valid = 1'b0;
        repeat (8) @(posedge clk);
    endtask

    initial begin
        logic [7:0] rs, ra;
        rst = 1'b1;
        vif.sample_valid = 1'b1;
        vif.sample_in    = 8'd5;
        vif.amplitude    = 8'd7;
        repeat (3) @(posedge clk);
        #3;
        check_eq("rst_product", vif.product_out, 0);
        check_eq("rst_valid", vif.product_valid, 0);
        check_eq("rst_pwm", pwm_out, 0);
        check_eq("rst_ready", vif.sample_ready, 1);
        check_eq("rst_state", dbg_state, 0);
        check_eq("rst_acc", dbg_acc, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        vif.sample_valid = 1'b0;
        repeat (2) @(posedge clk);

        // Multiply sweep, including the corner products.
        drive_sample(8'd255, 8'd255);
        drive_sample(8'd128, 8'd128);
        drive_sample(8'd200, 8'd0);
        drive_sample(8'd0,   8'd255);
        drive_sample(8'd1,   8'd128);
        drive_sample(8'd128, 8'd3);

        // Back-pressure: valid held high, sample changes every clock.
        @(posedge clk); #1;
        vif.amplitude    = 8'd150;
        vif.sample_in    = 8'd10;
        vif.sample_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            vif.sample_in = vif.sample_in + 8'd1;
        end
        vif.sample_valid = 1'b0;
        repeat (12) @(posedge clk);

        // Amplitude snapshot: amplitude drops to 0 three clocks after the handshake.
        @(posedge clk); #1;
        vif.sample_valid = 1'b1;
        vif.sample_in    = 8'd100;
        vif.amplitude    = 8'd200;
        @(posedge clk); #1;
        vif.sample_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 vif.amplitude = 8'd0;
        repeat (8) @(posedge clk);

        // PWM duty 64 for a few periods, then 192 loaded mid-period.
        drive_sample(8'd128, 8'd128);
        repeat (600) @(posedge clk);
        drive_sample(8'd255, 8'd193);
        repeat (600) @(posedge clk);

        // Shadow write on the same edge as the counter wrap: counter is 246 at the handshake edge.
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (m_cnt == 8'd245) break;
        end
        vif.sample_valid = 1'b1;
        vif.sample_in    = 8'd200;
        vif.amplitude    = 8'd200;
        @(posedge clk); #1;
        vif.sample_valid = 1'b0;
        repeat (700) @(posedge clk);

        // Reset four clocks into a multiply.
        @(posedge clk); #1;
        vif.sample_valid = 1'b1;
        vif.sample_in    = 8'd90;
        vif.amplitude    = 8'd90;
        @(posedge clk); #1;
        vif.sample_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #2;
        check_eq("midrst_valid", vif.product_valid, 0);
        check_eq("midrst_state", dbg_state, 0);
        check_eq("midrst_pwm", pwm_out, 0);
        check_eq("midrst_ready", vif.sample_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (12) @(posedge clk);
        drive_sample(8'd77, 8'd201);
        repeat (600) @(posedge clk);

        for (int i = 0; i < 8; i++) begin
            rs = 8'($urandom_range(0, 255));
            ra = 8'($urandom_range(0, 255));
            drive_sample(rs, ra);
        end

        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        check_eq("drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/envelope_vca_pwm.md
Name: envelope_vca_pwm

Overview:
- Downstream stage of the ADSR envelope generator: a voltage-controlled-amplifier (VCA) block.
- Multiplies an unsigned oscillator sample by the current 8-bit envelope amplitude using a sequential shift-add multiplier.
- Drives the scaled result onto a double-buffered 8-bit PWM output that feeds the board's RC audio filter.
- Sits between the oscillator/ADSR pair and the output pin.

Parameters:
- PWM_BITS, 8, PWM counter width; the period is 2^PWM_BITS clocks. Only 8 is supported; any other value is a configuration error.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- sample_in  input  8  unsigned oscillator sample
- sample_valid  input  1  sample_in is valid this cycle
- sample_ready  output  1  block can accept a sample (combinational, = state==IDLE)
- amplitude  input  8  envelope level from the ADSR generator
- product_out  output  8  scaled sample, registered
- product_valid  output  1  one-cycle pulse when product_out updates
- pwm_out  output  1  PWM DAC output, registered
- busy  output  1  high while in MUL or DONE

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values: state=IDLE, product_out=0, product_valid=0, pwm_out=0, busy=0, PWM counter=0, duty active=0, duty shadow=0, accumulator=0, bit counter=0.
- State machine: IDLE -> MUL -> DONE -> IDLE.
- IDLE:
  - sample_ready=1.
  - Handshake fires on sample_valid && sample_ready at edge T.
  - At T, sample_in and amplitude are snapshotted into multiplicand/multiplier registers, accumulator cleared, bit counter = 0, state -> MUL.
  - amplitude changes after T have no effect on the current product.
- MUL:
  - Runs exactly 8 cycles (T+1..T+8), LSB-first shift-add.
  - Each cycle: if multiplier bit set, add the shifted multiplicand into the 16-bit accumulator; shift; increment bit counter.
  - After cycle 8, state -> DONE.
  - sample_valid is ignored (sample_ready=0); no queueing.
- DONE (one cycle, T+9):
  - product_out <= result, product_valid=1, and the duty shadow register <= result.
  - state -> IDLE; sample_ready is high again at T+10.
- Latency: 9 clocks from handshake to product_valid. Maximum throughput is one sample per 10 clocks.
- Result arithmetic: exact 16-bit product P = sample*amplitude. Result width is 8 bits, per the optional feature. Maximum P=65025, so no overflow in either mode.
- amplitude=0 yields 0. sample=255 with amplitude=255 yields 254.
- PWM:
  - Free-running 8-bit counter, increments every clock, wraps 255->0.
  - pwm_out <= (counter < duty_active).
  - duty_active loads from the duty shadow only on the cycle the counter wraps 255->0, so there are no mid-period glitches.
  - duty=0: pwm_out is constantly 0.
  - duty=255: pwm_out is high for 255 of 256 clocks.
- Simultaneous events: a DONE write to the shadow in the same cycle as the wrap is not transferred; the shadow load wins and transfers at the next wrap.
- Reset mid-operation: asserting rst during MUL or DONE aborts immediately to reset values. No product_valid is emitted; the PWM restarts at counter 0 with duty 0.

Optional Feature:
- Macro VCA_ROUND_EN.
- Defined: result = (P + 128) >> 8, i.e. round-half-up. 255*255 gives 254; 1*128 gives 1.
- Undefined: result = P >> 8, i.e. truncation. 255*255 gives 254; 1*128 gives 0; 128*3 gives 1.
- The rounding adder exists only when the macro is defined.

Test Plan:
- Reset: hold rst high for 3 clocks with sample_valid=1. Required: product_out=0, product_valid=0, pwm_out=0, sample_ready=1. After release, the first accepted sample produces product_valid exactly 9 clocks after the handshake.
- Multiply sweep, with sample_valid pulses separated by 10 clocks:
  - (255,255) -> 254
  - (128,128) -> 64
  - (200,0) -> 0
  - (0,255) -> 0
  - (1,128) -> 1 with VCA_ROUND_EN, 0 without it
- Back-pressure: hold sample_valid=1 continuously with sample_in incrementing each clock. Required: exactly one accept per 10 clocks, sample_ready=0 during T+1..T+9, and each product matches the sample present at its handshake.
- Amplitude snapshot: accept (100,200), then change amplitude to 0 at T+3. Required: product 78 (round) / 78 (trunc); 20000>>8 = 78.
- PWM: produce results 64 then 192 mid-period. Required: in each full 256-clock period, pwm_out is high for exactly the first 64 clocks. The duty switch to 192 occurs only at the next counter wrap, with no partial period.
- Reset mid-multiply: assert rst at T+4. Required: no product_valid, state IDLE, pwm_out=0 and the counter restarts from 0. A fresh handshake after release completes normally.
